// File: rtl/psl_job_ctrl.sv
`default_nettype none
// ============================================================================
// psl_job_ctrl : PSL job-control front end (command decode, reset/start, done)
// Revision 1.0
// ============================================================================
module psl_job_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic        ha_pclock,
  input  logic        ha_preset_n,
  input  logic        ha_jval,
  input  logic [0:7]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [0:63] ha_jea,
  input  logic        ha_jeapar,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic [0:63] ah_jerror,
  output logic        ah_jyield,
  output logic        core_reset,
  output logic        core_start,
  output logic [0:63] core_wed,
  input  logic        core_done,
  input  logic [0:7]  core_error
);

  localparam int               CNT_W    = $clog2(RESET_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES);
  localparam logic [7:0]       CMD_RESET = 8'h80;
  localparam logic [7:0]       CMD_START = 8'h90;
  localparam logic [7:0]       CMD_LLCMD = 8'h45;

  typedef enum logic [1:0] {ST_IDLE, ST_RESETTING, ST_RUNNING} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [0:3]       r_sticky;
  logic             r_pend;
  logic [0:63]      r_pend_err;

  logic        w_jcom_perr, w_jea_perr, w_cmd_ok;
  logic        w_is_reset, w_is_start, w_is_llcmd, w_is_invalid;
  logic        w_abort, w_idle_perr, w_bad_start, w_complete, w_evt;
  logic [0:3]  w_sticky_nxt;
  logic [0:63] w_evt_err;

  assign ah_jyield = 1'b0;

  // Odd parity: a clean word has data XOR parity equal to 1.
  assign w_jcom_perr = PARITY_EN && ha_jval && !(^ha_jcom ^ ha_jcompar);
  assign w_jea_perr  = PARITY_EN && !(^ha_jea ^ ha_jeapar);
  assign w_cmd_ok    = ha_jval && !w_jcom_perr;

  assign w_is_reset   = w_cmd_ok && (ha_jcom == CMD_RESET);
  assign w_is_start   = w_cmd_ok && (ha_jcom == CMD_START);
  assign w_is_llcmd   = w_cmd_ok && (ha_jcom == CMD_LLCMD);
  assign w_is_invalid = w_cmd_ok && !w_is_reset && !w_is_start && !w_is_llcmd;

  assign w_abort     = w_jcom_perr && (r_state == ST_RUNNING);
  assign w_idle_perr = w_jcom_perr && (r_state == ST_IDLE);
  assign w_bad_start = w_is_start && w_jea_perr && (r_state == ST_IDLE);
  assign w_complete  = core_done && !w_jcom_perr && (r_state == ST_RUNNING);
  assign w_evt       = w_abort || w_idle_perr || w_bad_start || w_complete;

  always_comb begin
    w_sticky_nxt    = r_sticky;
    w_sticky_nxt[0] = r_sticky[0] | w_jcom_perr;
    w_sticky_nxt[2] = r_sticky[2] | (w_is_start && (r_state != ST_IDLE));
    w_sticky_nxt[3] = r_sticky[3] | w_is_invalid;
    w_evt_err        = '0;
    w_evt_err[0:3]   = w_sticky_nxt;
    w_evt_err[1]     = w_sticky_nxt[1] | w_bad_start;
    if (w_complete) begin
      w_evt_err[56:63] = core_error;
    end
  end

  always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
    if (!ha_preset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sticky    <= '0;
      r_pend      <= 1'b0;
      r_pend_err  <= '0;
      ah_jrunning <= 1'b0;
      ah_jdone    <= 1'b0;
      ah_jcack    <= 1'b0;
      ah_jerror   <= '0;
      core_reset  <= 1'b0;
      core_start  <= 1'b0;
      core_wed    <= '0;
    end else begin
      ah_jdone   <= 1'b0;
      ah_jcack   <= 1'b0;
      ah_jerror  <= '0;
      core_start <= 1'b0;
      if (w_is_reset) begin
        // Reset overrides everything, including a simultaneous core_done.
        r_state     <= ST_RESETTING;
        r_cnt       <= CNT_LOAD;
        core_reset  <= 1'b1;
        ah_jrunning <= 1'b0;
        r_sticky    <= '0;
        r_pend      <= 1'b0;
        r_pend_err  <= '0;
      end else begin
        core_reset <= 1'b0;
        r_sticky   <= w_sticky_nxt;
        case (r_state)
          ST_RESETTING: begin
            if (r_cnt == CNT_W'(1)) begin
              ah_jdone <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              core_reset <= 1'b1;
              r_cnt      <= r_cnt - CNT_W'(1);
            end
          end
          ST_IDLE: begin
            if (w_is_start && !w_jea_perr) begin
              core_wed    <= ha_jea;
              core_start  <= 1'b1;
              ah_jrunning <= 1'b1;
              r_state     <= ST_RUNNING;
            end
          end
          ST_RUNNING: begin
            if (w_abort) begin
              core_reset  <= 1'b1;
              ah_jrunning <= 1'b0;
              r_state     <= ST_IDLE;
            end else if (w_complete) begin
              ah_jrunning <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_is_llcmd && (r_state != ST_RESETTING)) begin
          ah_jcack <= 1'b1;
        end
        // A report landing right after a jdone pulse is held one cycle.
        if (w_evt || r_pend) begin
          r_sticky <= '0;
          if (ah_jdone) begin
            r_pend     <= 1'b1;
            r_pend_err <= r_pend_err | w_evt_err;
          end else begin
            ah_jdone   <= 1'b1;
            ah_jerror  <= r_pend_err | w_evt_err;
            r_pend     <= 1'b0;
            r_pend_err <= '0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psl_job_ctrl.sv
`default_nettype none
// ============================================================================
// tb_psl_job_ctrl : directed vector bench for psl_job_ctrl
// Revision 1.0
// ============================================================================
module tb_psl_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ha_jval;
  logic [0:7]  ha_jcom;
  logic        ha_jcompar;
  logic [0:63] ha_jea;
  logic        ha_jeapar;
  logic        ah_jrunning, ah_jdone, ah_jcack, ah_jyield;
  logic [0:63] ah_jerror;
  logic        core_reset, core_start, core_done;
  logic [0:63] core_wed;
  logic [0:7]  core_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psl_job_ctrl #(.RESET_CYCLES(4), .PARITY_EN(1'b1)) dut (
    .ha_pclock  (clk),
    .ha_preset_n(rst_n),
    .ha_jval    (ha_jval),
    .ha_jcom    (ha_jcom),
    .ha_jcompar (ha_jcompar),
    .ha_jea     (ha_jea),
    .ha_jeapar  (ha_jeapar),
    .ah_jrunning(ah_jrunning),
    .ah_jdone   (ah_jdone),
    .ah_jcack   (ah_jcack),
    .ah_jerror  (ah_jerror),
    .ah_jyield  (ah_jyield),
    .core_reset (core_reset),
    .core_start (core_start),
    .core_wed   (core_wed),
    .core_done  (core_done),
    .core_error (core_error)
  );

  typedef struct {
    logic        jv;
    logic [7:0]  jc;
    logic        bad_cp;
    logic [63:0] ea;
    logic        bad_ep;
    logic        cd;
    logic [7:0]  ce;
    logic        run, done, cack, crst, cst;
    logic [63:0] jerr;
    logic [63:0] wed;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] WA  = 64'h0000_0001_2345_6780;
  localparam logic [63:0] WB  = 64'hDEAD_BEEF_0000_1234;
  localparam logic [63:0] WC  = 64'h0000_0000_0000_1111;
  localparam logic [63:0] WD  = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] WE  = 64'h0000_0000_0000_ABCD;
  localparam logic [63:0] E0  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] E1  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] E2  = 64'h2000_0000_0000_0000;
  localparam logic [63:0] E03 = 64'h9000_0000_0000_0000;

  task automatic add(input logic jv, input logic [7:0] jc, input logic bcp,
                     input logic [63:0] ea, input logic bep, input logic cd,
                     input logic [7:0] ce, input logic run, input logic done,
                     input logic cack, input logic crst, input logic cst,
                     input logic [63:0] jerr, input logic [63:0] wed);
    vec_t v;
    v.jv = jv; v.jc = jc; v.bad_cp = bcp; v.ea = ea; v.bad_ep = bep;
    v.cd = cd; v.ce = ce; v.run = run; v.done = done; v.cack = cack;
    v.crst = crst; v.cst = cst; v.jerr = jerr; v.wed = wed;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic jv, input logic [7:0] jc, input logic bcp,
                       input logic [63:0] ea, input logic bep, input logic cd,
                       input logic [7:0] ce);
    ha_jval    = jv;
    ha_jcom    = jc;
    ha_jcompar = (~^jc) ^ bcp;
    ha_jea     = ea;
    ha_jeapar  = (~^ea) ^ bep;
    core_done  = cd;
    core_error = ce;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " flags"}, {58'd0, ah_jrunning, ah_jdone, ah_jcack, ah_jyield, core_reset, core_start}, 64'd0);
    check({nm, " jerror"}, ah_jerror, 64'd0);
    check({nm, " wed"}, core_wed, 64'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 64'd0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 64'd0, 1'b0, 1'b0, 8'h00);

    //  jv jcom  bcp ea   bep cd ce      run done cack crst cst jerr wed
    add(1, 8'h80, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, 64'd0);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, 64'd0);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, 64'd0);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, 64'd0);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 1, 0, 0, 0, 64'd0, 64'd0);
    add(1, 8'h90, 0, WA,    0, 0, 8'h00,  1, 0, 0, 0, 1, 64'd0, WA);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 64'd0, WA);
    add(0, 8'h00, 0, 64'd0, 0, 1, 8'h5A,  0, 1, 0, 0, 0, 64'h5A, WA);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 64'd0, WA);
    add(1, 8'h90, 0, WB,    1, 0, 8'h00,  0, 1, 0, 0, 0, E1,   WA);
    add(1, 8'h90, 0, WB,    0, 0, 8'h00,  1, 0, 0, 0, 1, 64'd0, WB);
    add(1, 8'h45, 0, 64'd0, 0, 0, 8'h00,  1, 0, 1, 0, 0, 64'd0, WB);
    add(1, 8'h90, 0, 64'h55, 0, 0, 8'h00, 1, 0, 0, 0, 0, 64'd0, WB);
    add(0, 8'h00, 0, 64'd0, 0, 1, 8'h00,  0, 1, 0, 0, 0, E2,   WB);
    add(1, 8'h90, 0, WC,    0, 0, 8'h00,  1, 0, 0, 0, 1, 64'd0, WC);
    add(1, 8'h80, 0, 64'd0, 0, 1, 8'h33,  0, 0, 0, 1, 0, 64'd0, WC);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WC);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WC);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WC);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 1, 0, 0, 0, 64'd0, WC);
    add(1, 8'h90, 0, WD,    0, 0, 8'h00,  1, 0, 0, 0, 1, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  1, 0, 0, 0, 0, 64'd0, WD);
    add(1, 8'h90, 1, 64'd0, 0, 0, 8'h00,  0, 1, 0, 1, 0, E0,   WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 64'd0, WD);
    add(1, 8'h12, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 64'd0, WD);
    add(1, 8'h45, 1, 64'd0, 0, 0, 8'h00,  0, 1, 0, 0, 0, E03,  WD);
    add(1, 8'h90, 0, WA,    1, 0, 8'h00,  0, 0, 0, 0, 0, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 1, 0, 0, 0, E1,   WD);
    add(1, 8'h45, 0, 64'd0, 0, 0, 8'h00,  0, 0, 1, 0, 0, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 1, 8'hFF,  0, 0, 0, 0, 0, 64'd0, WD);
    add(1, 8'h80, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WD);
    add(1, 8'h80, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WD);
    add(1, 8'h45, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 0, 0, 1, 0, 64'd0, WD);
    add(0, 8'h00, 0, 64'd0, 0, 0, 8'h00,  0, 1, 0, 0, 0, 64'd0, WD);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].jv, tbl[i].jc, tbl[i].bad_cp, tbl[i].ea, tbl[i].bad_ep, tbl[i].cd, tbl[i].ce);
      @(posedge clk);
      #1;
      check($sformatf("row%0d flags", i),
            {59'd0, ah_jrunning, ah_jdone, ah_jcack, core_reset, core_start},
            {59'd0, tbl[i].run, tbl[i].done, tbl[i].cack, tbl[i].crst, tbl[i].cst});
      check($sformatf("row%0d jerror", i), ah_jerror, tbl[i].jerr);
      check($sformatf("row%0d wed", i), core_wed, tbl[i].wed);
    end

    // Asynchronous reset in the middle of a reset sequence clears everything.
    @(negedge clk);
    drive(1'b1, 8'h90, 1'b0, WE, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("async start", {63'd0, core_start}, 64'd1);
    @(negedge clk);
    drive(1'b1, 8'h80, 1'b0, 64'd0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    idle_cycle();
    check("async pre reset", {63'd0, core_reset}, 64'd1);
    check("async pre wed", core_wed, WE);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    check_all_zero("after async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psl_job_ctrl.md
Name: psl_job_ctrl

Overview:
- Job-control front end of the AFU. Sits directly downstream of the PSL control interface and upstream of the AFU compute core.
- Decodes ha_jval/ha_jcom and checks control-interface parity. Latches the WED address and sequences reset and start.
- Drives ah_jrunning/ah_jdone/ah_jcack/ah_jerror on the PSL side, and a start/done handshake to the core.
- Replaces ad-hoc job handling in the AFU top.

Parameters:
- RESET_CYCLES, 4: cycles core_reset is held high after a reset command (min 1).
- PARITY_EN, 1: 1 = check odd parity on ha_jcom and ha_jea; 0 = ignore parity inputs.

Ports:
- ha_pclock  in  1  PSL clock; all logic on its rising edge.
- ha_preset_n  in  1  asynchronous active-low reset.
- ha_jval  in  1  job command valid, single-cycle.
- ha_jcom  in  [0:7]  job command code.
- ha_jcompar  in  1  odd parity over ha_jcom.
- ha_jea  in  [0:64-1]  job effective address (WED pointer).
- ha_jeapar  in  1  odd parity over ha_jea.
- ah_jrunning  out  1  job running.
- ah_jdone  out  1  job done, single-cycle pulse.
- ah_jcack  out  1  LLCMD acknowledge, single-cycle pulse.
- ah_jerror  out  [0:63]  error code; valid only while ah_jdone=1, else 0.
- ah_jyield  out  1  constant 0.
- core_reset  out  1  reset to compute core, level.
- core_start  out  1  start pulse to core, single-cycle.
- core_wed  out  [0:63]  latched WED address.
- core_done  in  1  core completion, single-cycle pulse.
- core_error  in  [0:7]  core status; sampled with core_done.

Behaviour:
- Async reset (ha_preset_n=0): state=IDLE; all outputs 0, including core_wed, core_reset and sticky flags.
- All outputs are registered. "T" is the edge at which ha_jval=1 is sampled.
- Command codes: 0x80 RESET, 0x90 START, 0x45 LLCMD; anything else is INVALID.
- Parity (PARITY_EN=1): error when the XOR of the data bits XOR the parity bit is 0. A jcom parity error discards the command.
- States: IDLE, RESETTING, RUNNING.
- RESET, accepted in any state:
  - state=RESETTING and core_reset=1 from T+1 through T+RESET_CYCLES.
  - ah_jrunning=0 from T+1.
  - Down-counter (width ceil(log2(RESET_CYCLES))+1) is loaded at T.
  - At T+RESET_CYCLES+1: core_reset=0, ah_jdone=1 for one cycle, ah_jerror=0, state=IDLE.
  - Sticky flags are cleared.
  - A RESET received while RESETTING restarts the count.
- START in IDLE:
  - If ha_jea has a parity error: no start; ah_jdone=1 at T+1 with jerror bit 1 set; stays IDLE.
  - Otherwise: core_wed<=ha_jea at T+1; core_start=1 for cycle T+1 only; ah_jrunning=1 from T+1; state=RUNNING.
- START in RUNNING or RESETTING: ignored; sticky bit 2 is set.
- RUNNING and core_done=1 at edge E: at E+1, ah_jdone=1 for one cycle and ah_jrunning=0.
  - ah_jerror[56:63]=core_error; bits 0..3 = sticky flags; other bits 0.
  - state=IDLE; sticky flags cleared.
- core_done outside RUNNING: ignored.
- LLCMD in IDLE or RUNNING: ah_jcack=1 at T+1 for one cycle; state unchanged. In RESETTING: ignored.
- INVALID command: sets sticky bit 3; no other effect.
- jcom parity error:
  - Sets sticky bit 0.
  - In RUNNING: job aborts. At T+1: ah_jdone=1, ah_jrunning=0, core_reset=1 for one cycle, state=IDLE.
  - In IDLE: ah_jdone=1 at T+1 with bit 0 set.
- Simultaneous RESET ha_jval and core_done: RESET wins; no completion jdone; only the reset jdone is produced.
- Sticky flags are reported, then cleared, on every ah_jdone pulse except the reset jdone.
- Never two ah_jdone pulses on consecutive cycles.

Test Plan:
- Reset then RESET (0x80, correct parity), RESETTING=4 -> core_reset=1 for cycles T+1..T+4; ah_jdone=1 only at T+5; ah_jerror=0.
- START with ha_jea=0x0000_0001_2345_6780 -> at T+1: core_start pulse, core_wed equals ha_jea, ah_jrunning=1. Then core_done with core_error=0x5A at edge E -> at E+1: ah_jdone=1, ah_jerror=0x5A, ah_jrunning=0.
- START with bad ha_jeapar -> no core_start; ah_jdone at T+1 with ah_jerror bit 1 set (0x4000_0000_0000_0000).
- Running job, then LLCMD 0x45 -> ah_jcack pulse at T+1; ah_jrunning stays 1. Then START 0x90 -> ignored. Then core_done with core_error=0 -> ah_jerror=0x2000_0000_0000_0000.
- Running job, RESET in the same cycle as core_done -> single jdone at T+RESET_CYCLES+1 with ah_jerror=0. Then ha_preset_n low mid-RESETTING -> all outputs 0 immediately.
- Running job, command with bad ha_jcompar -> abort: ah_jdone at T+1, ah_jerror=0x8000_0000_0000_0000, one-cycle core_reset.
